// File: rtl/pkt_buffer_134b.sv
// Per-port packet store: writes 134b lines into fixed-size slots and streams them back out on request.
// Latency: a stored line appears on out_pkt_data two cycles after rd_req, then lines follow back-to-back.
// Backpressure: ingress is never stalled (packets are dropped when no slot is free); rd_ready gates rd_req/free_req.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pkt_data[133:0]     ingress line: [133:132] 01 head / 10 tail / 00 body, [131:128] valid bytes, [127:0] data
//   pkt_data_valid      ingress line strobe
//   bufferID[15:0]      {PORT_ID, slot} of the next free slot, 16'hffff when none is free
//   rd_req, rd_bufferID read a slot out and return it to the free list
//   free_req, free_bufferID  return a slot to the free list without readout
//   rd_ready            read/free port idle
//   out_pkt_data[133:0], out_pkt_data_valid  stored lines, tags as written
//   drop_cnt[31:0]      packets discarded at ingress for lack of a free slot
module pkt_buffer_134b #(
    parameter logic [1:0] PORT_ID    = 2'd0,
    parameter int         SLOT_NUM   = 8,
    parameter int         SLOT_DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] pkt_data,
    input  logic         pkt_data_valid,
    output logic [15:0]  bufferID,
    input  logic         rd_req,
    input  logic [15:0]  rd_bufferID,
    input  logic         free_req,
    input  logic [15:0]  free_bufferID,
    output logic         rd_ready,
    output logic [133:0] out_pkt_data,
    output logic         out_pkt_data_valid,
    output logic [31:0]  drop_cnt
);

    localparam int SW = $clog2(SLOT_NUM);
    localparam int OW = $clog2(SLOT_DEPTH);

    typedef logic [SW-1:0]    slot_t;
    typedef logic [SW:0]      fcnt_t;   // free-list occupancy, 0..SLOT_NUM
    typedef logic [OW:0]      len_t;    // line count, 0..SLOT_DEPTH
    typedef logic [OW-1:0]    off_t;
    typedef logic [SW+OW-1:0] addr_t;

    localparam len_t DEPTH_C = len_t'(SLOT_DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_PKT  = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_BUSY = 1'b1;

    // ------------------------------------------------------------------
    // Line decode
    // ------------------------------------------------------------------
    logic is_head, is_tail;
    assign is_head = (pkt_data[133:132] == 2'b01);
    assign is_tail = (pkt_data[133:132] == 2'b10);

    // ------------------------------------------------------------------
    // Free list: circular FIFO of slot indices
    // ------------------------------------------------------------------
    slot_t       fl_mem [SLOT_NUM];
    slot_t       fl_head, fl_tail;
    fcnt_t       fl_cnt;
    logic        fl_empty;
    logic        fl_pop, fl_push;
    slot_t       push_slot;
    fcnt_t       fl_cnt_nxt;
    slot_t       nxt_head_slot;
    logic [15:0] bid_nxt;
    logic [15:0] buffer_id_q;

    assign fl_empty = (fl_cnt == '0);

    always_comb begin
        fl_cnt_nxt = fl_cnt;
        if (fl_push && !fl_pop) begin
            fl_cnt_nxt = fl_cnt + fcnt_t'(1);
        end else if (fl_pop && !fl_push) begin
            fl_cnt_nxt = fl_cnt - fcnt_t'(1);
        end

        // When the list is empty, or holds only the entry being popped, the
        // slot being pushed this cycle becomes the new head.
        nxt_head_slot = fl_mem[fl_head + slot_t'(1)];
        if (fl_push && (fl_empty || (fl_pop && fl_cnt == fcnt_t'(1)))) begin
            nxt_head_slot = push_slot;
        end

        bid_nxt = 16'hffff;
        if (fl_cnt_nxt != '0) begin
            bid_nxt = {PORT_ID, 14'(nxt_head_slot)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                fl_mem[i] <= slot_t'(i);
            end
            fl_head     <= '0;
            fl_tail     <= '0;
            fl_cnt      <= fcnt_t'(SLOT_NUM);
            buffer_id_q <= {PORT_ID, 14'd0};
        end else begin
            if (fl_push) begin
                fl_mem[fl_tail] <= push_slot;
                fl_tail         <= fl_tail + slot_t'(1);
            end
            if (fl_pop) begin
                fl_head <= fl_head + slot_t'(1);
            end
            fl_cnt <= fl_cnt_nxt;
            // bufferID only moves when the head entry actually changes, so it
            // stays stable for the whole duration of a packet write.
            if (fl_pop || (fl_push && fl_empty)) begin
                buffer_id_q <= bid_nxt;
            end
        end
    end

    assign bufferID = buffer_id_q;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    logic [1:0]  w_state;
    slot_t       w_slot;
    len_t        w_cnt;      // lines seen so far, saturates at SLOT_DEPTH
    logic [31:0] drop_cnt_q;
    logic        wr_en;
    slot_t       wr_slot;
    off_t        wr_off;
    len_t        commit_len;

    always_comb begin
        wr_en      = 1'b0;
        wr_off     = '0;
        fl_pop     = 1'b0;
        wr_slot    = (w_state == W_IDLE) ? fl_mem[fl_head] : w_slot;
        commit_len = (w_cnt == DEPTH_C) ? DEPTH_C : (w_cnt + len_t'(1));
        case (w_state)
            W_IDLE: begin
                if (pkt_data_valid && is_head && !fl_empty) begin
                    wr_en = 1'b1;
                end
            end
            W_PKT: begin
                if (pkt_data_valid) begin
                    if (is_head) begin
                        // Restart: overwrite the same slot from offset 0.
                        wr_en = 1'b1;
                    end else begin
                        // Lines past the slot size are discarded, but the
                        // tail still commits the (truncated) packet.
                        wr_en  = (w_cnt != DEPTH_C);
                        wr_off = w_cnt[OW-1:0];
                        fl_pop = is_tail && !fl_empty;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state    <= W_IDLE;
            w_slot     <= '0;
            w_cnt      <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (pkt_data_valid && is_head) begin
                        if (!fl_empty) begin
                            w_slot  <= fl_mem[fl_head];
                            w_cnt   <= len_t'(1);
                            w_state <= W_PKT;
                        end else begin
                            drop_cnt_q <= drop_cnt_q + 32'd1;
                            w_state    <= W_DROP;
                        end
                    end
                end
                W_PKT: begin
                    if (pkt_data_valid) begin
                        if (is_head) begin
                            w_cnt <= len_t'(1);
                        end else if (is_tail) begin
                            w_state <= W_IDLE;
                        end else if (w_cnt != DEPTH_C) begin
                            w_cnt <= w_cnt + len_t'(1);
                        end
                    end
                end
                W_DROP: begin
                    if (pkt_data_valid && is_tail) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign drop_cnt = drop_cnt_q;

    // ------------------------------------------------------------------
    // Length table: committed line count per slot, 0 when empty
    // ------------------------------------------------------------------
    len_t len_tab [SLOT_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                len_tab[i] <= '0;
            end
        end else begin
            if (fl_push) begin
                len_tab[push_slot] <= '0;
            end
            if (fl_pop) begin
                len_tab[w_slot] <= commit_len;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    slot_t      r_slot;
    len_t       r_len;
    len_t       r_off;        // next offset to issue
    logic       push_q;       // deferred push from free_req / empty-slot read
    slot_t      push_slot_q;
    logic       rd_en;
    logic       rd_done;
    logic       out_vld_q;
    slot_t      rd_req_slot;
    slot_t      free_req_slot;

    assign rd_req_slot   = rd_bufferID[SW-1:0];
    assign free_req_slot = free_bufferID[SW-1:0];

    assign rd_ready = (r_state == R_IDLE);
    assign rd_en    = (r_state == R_BUSY) && (r_off != r_len);
    // All reads issued and the final line is on the output this cycle.
    assign rd_done  = (r_state == R_BUSY) && (r_off == r_len) && out_vld_q;

    // A deferred push is only ever armed from R_IDLE without entering
    // R_BUSY, so it can never coincide with a read completion.
    assign fl_push   = rd_done || push_q;
    assign push_slot = rd_done ? r_slot : push_slot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= R_IDLE;
            r_slot      <= '0;
            r_len       <= '0;
            r_off       <= '0;
            push_q      <= 1'b0;
            push_slot_q <= '0;
        end else begin
            push_q <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (rd_req) begin
                        if (len_tab[rd_req_slot] == '0) begin
                            push_q      <= 1'b1;
                            push_slot_q <= rd_req_slot;
                        end else begin
                            r_slot  <= rd_req_slot;
                            r_len   <= len_tab[rd_req_slot];
                            r_off   <= '0;
                            r_state <= R_BUSY;
                        end
                    end else if (free_req) begin
                        push_q      <= 1'b1;
                        push_slot_q <= free_req_slot;
                    end
                end
                R_BUSY: begin
                    if (rd_en) begin
                        r_off <= r_off + len_t'(1);
                    end
                    if (rd_done) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet RAM: simple dual port, one-cycle registered read
    // ------------------------------------------------------------------
    logic [133:0] mem [SLOT_NUM*SLOT_DEPTH];
    logic [133:0] ram_q;
    addr_t        wr_addr, rd_addr;

    assign wr_addr = {wr_slot, wr_off};
    assign rd_addr = {r_slot, r_off[OW-1:0]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= pkt_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= rd_en;
        end
    end

    // Masking keeps the output at zero whenever no line is being presented.
    assign out_pkt_data_valid = out_vld_q;
    assign out_pkt_data       = out_vld_q ? ram_q : '0;

    logic unused_id_bits;
    assign unused_id_bits = ^{rd_bufferID[15:SW], free_bufferID[15:SW]};

endmodule

// File: tb/tb_pkt_buffer_134b.sv
module tb_pkt_buffer_134b;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [133:0] pkt_data;
    logic         pkt_data_valid;
    logic [15:0]  bufferID;
    logic         rd_req;
    logic [15:0]  rd_bufferID;
    logic         free_req;
    logic [15:0]  free_bufferID;
    logic         rd_ready;
    logic [133:0] out_pkt_data;
    logic         out_pkt_data_valid;
    logic [31:0]  drop_cnt;

    always #5 clk = ~clk;

    pkt_buffer_134b #(
        .PORT_ID   (2'd0),
        .SLOT_NUM  (8),
        .SLOT_DEPTH(256)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pkt_data          (pkt_data),
        .pkt_data_valid    (pkt_data_valid),
        .bufferID          (bufferID),
        .rd_req            (rd_req),
        .rd_bufferID       (rd_bufferID),
        .free_req          (free_req),
        .free_bufferID     (free_bufferID),
        .rd_ready          (rd_ready),
        .out_pkt_data      (out_pkt_data),
        .out_pkt_data_valid(out_pkt_data_valid),
        .drop_cnt          (drop_cnt)
    );

    typedef struct {
        logic [133:0] dat;
        int           cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         slot_pid [8];
    int         slot_n   [8];
    logic [3:0] slot_vb  [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [133:0] act, input logic [133:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: every presented line must match the queue head,
    // both in content and in the cycle it was predicted for.
    always @(negedge clk) begin
        exp_t e;
        if (out_pkt_data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got line %h, required no output", out_pkt_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_pkt_data, e.dat);
                check("out_cycle", 134'(cyc), 134'(e.cyc));
            end
        end
    end

    function automatic logic [133:0] gen_line(input int pid, input int i, input int n, input logic [3:0] vb);
        logic [1:0] tag;
        logic [3:0] v;
        tag = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b00);
        v   = (i == n - 1) ? vb : 4'hf;
        return {tag, v, 32'(pid), 32'(i), 64'h0123_4567_89ab_cdef ^ {32'(i), 32'(pid)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input logic [133:0] d);
        pkt_data       = d;
        pkt_data_valid = 1'b1;
        step();
        pkt_data_valid = 1'b0;
    endtask

    // slot < 0: packet is expected to be dropped, nothing recorded.
    task automatic send_pkt(input int pid, input int n, input logic [3:0] vb, input int slot);
        for (int i = 0; i < n; i++) begin
            send_line(gen_line(pid, i, n, vb));
        end
        if (slot >= 0) begin
            slot_pid[slot] = pid;
            slot_n[slot]   = n;
            slot_vb[slot]  = vb;
        end
    endtask

    task automatic push_expected(input int s);
        exp_t e;
        int   n;
        n = (slot_n[s] > 256) ? 256 : slot_n[s];
        for (int i = 0; i < n; i++) begin
            e.dat = gen_line(slot_pid[s], i, slot_n[s], slot_vb[s]);
            e.cyc = cyc + 2 + i;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            step();
            b--;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL read_timeout: %0d lines still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic read_pkt(input int s);
        push_expected(s);
        rd_req      = 1'b1;
        rd_bufferID = 16'(s);
        step();
        rd_req = 1'b0;
        check("rd_ready_busy", 134'(rd_ready), 134'(0));
        wait_drain(slot_n[s] + 8);
        step();
        step();
        check("rd_ready_idle", 134'(rd_ready), 134'(1));
    endtask

    task automatic free_slot(input int s);
        free_req      = 1'b1;
        free_bufferID = 16'(s);
        step();
        free_req = 1'b0;
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        pkt_data       = '0;
        pkt_data_valid = 1'b0;
        rd_req         = 1'b0;
        rd_bufferID    = '0;
        free_req       = 1'b0;
        free_bufferID  = '0;
        for (int i = 0; i < 8; i++) begin
            slot_pid[i] = 0;
            slot_n[i]   = 0;
            slot_vb[i]  = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_bufferID", 134'(bufferID), 134'(16'h0000));
        check("rst_rd_ready", 134'(rd_ready), 134'(1));
        check("rst_out_valid", 134'(out_pkt_data_valid), 134'(0));
        check("rst_out_data", out_pkt_data, 134'(0));
        check("rst_drop_cnt", 134'(drop_cnt), 134'(0));
        rst_n = 1'b1;
        step();

        // Basic 4-line packet into slot 0 and readout.
        send_pkt(1, 4, 4'h5, 0);
        check("t1_bufferID", 134'(bufferID), 134'(16'h0001));
        read_pkt(0);
        check("t1_bufferID_after_rd", 134'(bufferID), 134'(16'h0001));

        // Fill all 8 slots (order 1..7,0), then overflow.
        for (int i = 0; i < 8; i++) begin
            send_pkt(10 + i, 2, 4'h3, (i + 1) % 8);
            check("fill_bufferID", 134'(bufferID), (i == 7) ? 134'(16'hffff) : 134'(16'((i + 2) % 8)));
        end
        send_pkt(99, 3, 4'h1, -1);
        check("ovf_drop_cnt", 134'(drop_cnt), 134'(1));
        check("ovf_bufferID", 134'(bufferID), 134'(16'hffff));
        free_req      = 1'b1;
        free_bufferID = 16'd3;
        step();
        free_req = 1'b0;
        check("free_bid_hold", 134'(bufferID), 134'(16'hffff));
        step();
        check("free_bid_new", 134'(bufferID), 134'(16'h0003));

        // Tail commit (into slot 3) on the same cycle slot 1 readout completes.
        push_expected(1);
        rd_req      = 1'b1;
        rd_bufferID = 16'd1;
        step();
        rd_req = 1'b0;
        send_pkt(20, 3, 4'h7, 3);
        check("simul_bufferID", 134'(bufferID), 134'(16'h0001));
        wait_drain(10);
        step();
        check("simul_rd_ready", 134'(rd_ready), 134'(1));
        send_pkt(21, 2, 4'h2, 1);
        check("simul_cnt_one", 134'(bufferID), 134'(16'hffff));

        // Oversize packet truncated to 256 lines.
        read_pkt(3);
        check("t5_bid_after_rd", 134'(bufferID), 134'(16'h0003));
        free_slot(4);
        check("t5_bid_after_free", 134'(bufferID), 134'(16'h0003));
        send_pkt(30, 300, 4'h3, 3);
        check("big_bufferID", 134'(bufferID), 134'(16'h0004));
        read_pkt(3);
        check("big_bid_after_rd", 134'(bufferID), 134'(16'h0004));
        send_pkt(31, 2, 4'h9, 4);
        check("next_slot_bid", 134'(bufferID), 134'(16'h0003));
        read_pkt(4);

        // Head, body, then a second head before any tail.
        send_line(gen_line(40, 0, 3, 4'h1));
        send_line(gen_line(40, 1, 3, 4'h1));
        check("restart_bid_hold", 134'(bufferID), 134'(16'h0003));
        send_pkt(41, 3, 4'hc, 3);
        check("restart_bid", 134'(bufferID), 134'(16'h0004));
        read_pkt(3);
        send_pkt(42, 2, 4'h1, 4);
        check("restart_cnt_a", 134'(bufferID), 134'(16'h0003));
        send_pkt(43, 2, 4'h1, 3);
        check("restart_cnt_b", 134'(bufferID), 134'(16'hffff));
        check("restart_drop_cnt", 134'(drop_cnt), 134'(1));

        // Reset while line 2 of a 5-line readout is on the output.
        free_slot(5);
        check("t7_free_bid", 134'(bufferID), 134'(16'h0005));
        send_pkt(50, 5, 4'h6, 5);
        check("t7_bid_full", 134'(bufferID), 134'(16'hffff));
        push_expected(5);
        rd_req      = 1'b1;
        rd_bufferID = 16'd5;
        step();
        rd_req = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_remaining", 134'(exp_q.size()), 134'(3));
        exp_q.delete();
        check("mid_rst_out_valid", 134'(out_pkt_data_valid), 134'(0));
        check("mid_rst_out_data", out_pkt_data, 134'(0));
        check("mid_rst_rd_ready", 134'(rd_ready), 134'(1));
        check("mid_rst_bufferID", 134'(bufferID), 134'(16'h0000));
        check("mid_rst_drop_cnt", 134'(drop_cnt), 134'(0));
        #1;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            send_pkt(60 + i, 2, 4'h4, i);
            check("post_rst_fill", 134'(bufferID), (i == 7) ? 134'(16'hffff) : 134'(16'(i + 1)));
        end
        read_pkt(2);
        repeat (4) step();
        check("queue_empty", 134'(exp_q.size()), 134'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_buffer_134b.md
Name: pkt_buffer_134b

Overview:
Per-port packet store sitting directly downstream of the GMII-to-134b accumulator. It writes 134b packet lines into fixed-size slots and presents the next free slot as bufferID (16'hffff when none is free), which the accumulator uses for admission and metadata. It streams a stored packet back out on a read request from the scheduler and returns slots to a free list after readout or an explicit drop.

Parameters:
PORT_ID, 2'd0, port tag placed in bufferID[15:14]
SLOT_NUM, 8, number of packet slots (power of 2, max 2^14)
SLOT_DEPTH, 256, 134b lines per slot (power of 2, ≥132)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pkt_data  in  134  line in: [133:132] 01 head / 10 tail / 00 body, [131:128] valid, [127:0] data
pkt_data_valid  in  1  line strobe
bufferID  out  16  {PORT_ID, slot index} of next free slot, 16'hffff if free list empty
rd_req  in  1  read-and-free pulse
rd_bufferID  in  16  slot to read ([13:0] used)
free_req  in  1  drop-and-free pulse
free_bufferID  in  16  slot to drop ([13:0] used)
rd_ready  out  1  read/free port idle
out_pkt_data  out  134  stored line, tags as written
out_pkt_data_valid  out  1  output strobe
drop_cnt  out  32  packets discarded at ingress

Behaviour:
- Reset (asynchronous, any time including mid-write or mid-read): free list reloaded with 0..SLOT_NUM-1 in order (head = 0), length table cleared, in-flight write and read abandoned. Outputs: bufferID = {PORT_ID,14'd0}, rd_ready = 1, out_pkt_data = 0, out_pkt_data_valid = 0, drop_cnt = 0.
- Free list: circular FIFO of slot indices with count. bufferID is registered from the FIFO head and is stable while a packet is being written. It changes only on the cycle after a pop or after a push into an empty list.
- Write FSM (W_IDLE, W_PKT, W_DROP):
  - W_IDLE with a head line: if the list is non-empty, latch the head slot, write the line at offset 0, set line count to 1, go to W_PKT. If the list is empty, go to W_DROP and increment drop_cnt.
  - W_IDLE with a body or tail line: ignore.
  - W_PKT: each valid line is written at slot*SLOT_DEPTH + count while count < SLOT_DEPTH. Lines beyond that are dropped, but count saturates and tail handling still applies.
  - W_PKT tail line: store len = min(count+1, SLOT_DEPTH) in the length table, pop the free list, go to W_IDLE.
  - W_PKT head line: restart at offset 0 in the same slot; the partial packet is discarded without a pop.
  - W_DROP: discard lines until a tail line, then go to W_IDLE.
  - A single-line packet (tail with no prior head) is never admitted.
- Read FSM (R_IDLE, R_BUSY):
  - rd_ready = (state == R_IDLE). rd_req/free_req are sampled only when rd_ready = 1.
  - rd_req: latch slot and len, go to R_BUSY. Issue one RAM read per cycle for offsets 0..len-1. The RAM has 1-cycle read latency, so the first out_pkt_data_valid appears 2 cycles after rd_req. Lines are back-to-back, len cycles total.
  - On the cycle the last line is output: push the slot to the free list, clear its len, and return to R_IDLE.
  - rd_req to a slot with len = 0: no output; the slot is still pushed (treated as free).
  - free_req: push the slot next cycle; no output.
  - rd_req and free_req in the same cycle: rd_req is served and free_req is ignored (caller error).
- Simultaneous pop (tail commit) and push (read or free completion): both take effect, and the count is unchanged. Freeing a slot that is already free is a caller error and is not detected.
- Storage: a single simple-dual-port RAM of SLOT_NUM*SLOT_DEPTH × 134b, with the write port owned by the write FSM and the read port by the read FSM. Reading the slot currently being written is a caller error.

Test Plan:
- After reset, bufferID = 16'h0000 (PORT_ID=0). Write a 4-line packet (head, 2 body, tail valid=4'h5) → bufferID becomes 16'h0001 one cycle after the tail. rd_req rd_bufferID=0 → 4 lines identical to the input, first 2 cycles after the request, back-to-back. rd_ready returns to 1 after the last line.
- Admit 8 packets with SLOT_NUM=8 → bufferID = 16'hffff. A 9th head line → discarded through its tail, drop_cnt = 1. free_req slot 3 → bufferID = 16'h0003.
- 300-line packet → 256 lines stored, len = 256, readout yields exactly 256 lines. The next packet uses the next slot.
- Tail commit and read-completion push on the same cycle with 1 slot free → the count stays 1, and bufferID shows the pushed slot after the pop.
- Head, body, then a second head before any tail → only the second packet is stored in the same slot, and the free-list count drops by exactly 1.
- rst_n low mid-readout (line 2 of 5) → out_pkt_data_valid = 0 immediately, rd_ready = 1, bufferID = 16'h0000, free count = SLOT_NUM.
